// File: rtl/retire_trace_tx.sv
// Retire trace transmitter. It captures retired register writes and committed
// stores into an order-preserving FIFO, then serialises each record as 32-bit
// words over a valid/ready stream.
module retire_trace_tx #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     st_valid,
  input  logic [31:0]              st_pc,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [31:0]              tx_data,
  output logic                     tx_last,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Record layout: {is_store, seq[15:0], rd[4:0], pc[31:0], addr[31:0], data[31:0]}
  localparam int unsigned RW = 1 + 16 + 5 + 32 + 32 + 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_ADDR,
    S_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   mem_q [DEPTH];
  logic [RW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_count_q, drop_count_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_last_q, tx_last_d;
  logic [31:0]     tx_data_q, tx_data_d;

  logic            reg_off_c, st_off_c;
  logic            reg_acc_c, st_acc_c;
  logic [CW-1:0]   free_c;
  logic [1:0]      n_off_c, n_acc_c, n_drop_c;
  logic            handshake_c, pop_c;
  logic [16:0]     drop_sum_c;
  logic [RW-1:0]   head_c, out_rec_c;

  assign handshake_c = tx_valid_q && tx_ready;
  assign pop_c       = handshake_c && (state_q == S_DATA);

  // Admission: decide which offered records fit, based on occupancy at cycle start.
  always_comb begin
    reg_off_c = wb_valid && (wb_rd != 5'd0);
    st_off_c  = st_valid;
    free_c    = CW'(DEPTH) - count_q;
    reg_acc_c = 1'b0;
    st_acc_c  = 1'b0;
    if (free_c >= CW'(2)) begin
      reg_acc_c = reg_off_c;
      st_acc_c  = st_off_c;
    end else if (free_c == CW'(1)) begin
      reg_acc_c = reg_off_c;
      st_acc_c  = st_off_c && !reg_off_c;
    end
    n_off_c  = {1'b0, reg_off_c} + {1'b0, st_off_c};
    n_acc_c  = {1'b0, reg_acc_c} + {1'b0, st_acc_c};
    n_drop_c = n_off_c - n_acc_c;
  end

  // FIFO storage, pointers, sequence numbering and loss accounting.
  always_comb begin
    mem_d = mem_q;
    if (reg_acc_c) begin
      mem_d[wr_ptr_q] = {1'b0, seq_q, wb_rd, wb_pc, 32'h0, wb_data};
    end
    if (st_acc_c) begin
      // STORE lands behind a same-cycle REG and takes the following sequence number.
      mem_d[wr_ptr_q + AW'(reg_acc_c)] =
        {1'b1, seq_q + 16'(reg_off_c), 5'd0, st_pc, st_addr, st_data};
    end
    wr_ptr_d     = wr_ptr_q + AW'(n_acc_c);
    rd_ptr_d     = rd_ptr_q + AW'(pop_c);
    count_d      = count_q + CW'(n_acc_c) - CW'(pop_c);
    seq_d        = seq_q + 16'(n_off_c);
    overflow_d   = overflow_q || (n_drop_c != 2'd0);
    drop_sum_c   = 17'(drop_count_q) + 17'(n_drop_c);
    drop_count_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
  end

  // Serializer: next state and the registered word presented in that state.
  always_comb begin
    state_d = state_q;
    head_c  = mem_q[rd_ptr_q];
    case (state_q)
      S_IDLE: if (count_q != CW'(0)) state_d = S_HDR;
      S_HDR:  if (handshake_c) state_d = S_PC;
      S_PC:   if (handshake_c) state_d = head_c[RW-1] ? S_ADDR : S_DATA;
      S_ADDR: if (handshake_c) state_d = S_DATA;
      S_DATA: if (handshake_c) state_d = (count_q >= CW'(2)) ? S_HDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Finishing a record moves the presented word onto the next queued entry.
    out_rec_c = pop_c ? mem_q[rd_ptr_q + AW'(1)] : head_c;

    tx_data_d = 32'h0;
    case (state_d)
      S_HDR:  tx_data_d = {(out_rec_c[RW-1] ? 2'b10 : 2'b01), 9'd0,
                           out_rec_c[100:96], out_rec_c[116:101]};
      S_PC:   tx_data_d = out_rec_c[95:64];
      S_ADDR: tx_data_d = out_rec_c[63:32];
      S_DATA: tx_data_d = out_rec_c[31:0];
      default: tx_data_d = 32'h0;
    endcase
    tx_valid_d = (state_d != S_IDLE);
    tx_last_d  = (state_d == S_DATA);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= 16'h0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'h0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_data_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Record payload storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign level      = count_q;

endmodule
